// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and memory.
// The master issues one word read at a time and holds it until acknowledged.
interface instruction_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch unit with alignment check, request timeout,
// flush/discard handling and a latched fault record.
module instruction_fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [31:0]                     pc,
    input  logic                            fetch_en,
    input  logic                            flush,
    input  logic                            fault_clr,
    instruction_fetch_unit_if.master        imem,
    output logic [31:0]                     instr,
    output logic                            instr_valid,
    output logic                            pc_stall,
    output logic                            fault,
    output logic [1:0]                      fault_code,
    output logic [31:0]                     fault_pc
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone,
        StFault
    } state_e;

    localparam logic [1:0] CodeNone       = 2'b00;
    localparam logic [1:0] CodeMisaligned = 2'b01;
    localparam logic [1:0] CodeTimeout    = 2'b10;

    // Count value seen on the last permitted ack-less REQ cycle.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [1:0]  code_q, code_d;
    logic [31:0] fpc_q, fpc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        discard_q, discard_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            instr_q   <= '0;
            code_q    <= CodeNone;
            fpc_q     <= '0;
            cnt_q     <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            code_q    <= code_d;
            fpc_q     <= fpc_d;
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        code_d    = code_q;
        fpc_d     = fpc_q;
        cnt_d     = cnt_q;
        discard_d = discard_q;

        unique case (state_q)
            StIdle: begin
                if (fetch_en) begin
                    if (pc[1:0] != 2'b00) begin
                        state_d = StFault;
                        code_d  = CodeMisaligned;
                        fpc_d   = pc;
                    end else begin
                        state_d   = StReq;
                        addr_d    = pc;
                        cnt_d     = '0;
                        discard_d = 1'b0;
                    end
                end
            end
            StReq: begin
                // A flush in the ack cycle itself also discards the returning word.
                if (imem.imem_ack) begin
                    if (discard_q || flush) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StDone;
                        instr_d = imem.imem_rdata;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StFault;
                    code_d  = CodeTimeout;
                    fpc_d   = addr_q;
                end else begin
                    cnt_d     = cnt_q + 8'd1;
                    discard_d = discard_q | flush;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StFault: begin
                if (fault_clr) begin
                    state_d = StIdle;
                    code_d  = CodeNone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign imem.imem_req  = (state_q == StReq);
    assign imem.imem_addr = addr_q;

    assign instr       = instr_q;
    assign instr_valid = (state_q == StDone) && !flush;
    assign fault       = (state_q == StFault);
    assign fault_code  = code_q;
    assign fault_pc    = fpc_q;

    // fetch_en feeds pc_stall combinationally, so mask it while reset is held.
    always_comb begin
        pc_stall = 1'b0;
        unique case (state_q)
            StIdle:  pc_stall = fetch_en;
            StReq:   pc_stall = 1'b1;
            StDone:  pc_stall = 1'b0;
            StFault: pc_stall = 1'b1;
            default: pc_stall = 1'b0;
        endcase
        pc_stall = pc_stall & reset_n;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a per-cycle vector table followed by
// hand-written reset-during-request sequences.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc;
    logic        fetch_en;
    logic        flush;
    logic        fault_clr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        pc_stall;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] fault_pc;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit_if imem_bus ();

    instruction_fetch_unit #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .fault_clr   (fault_clr),
        .imem        (imem_bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_stall    (pc_stall),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_pc    (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied for one cycle; expected outputs are the pre-edge view.
    typedef struct {
        logic [31:0] fe, pc, fl, fc, ack, rdata;
        logic [31:0] req, addr, instr, iv, stall, flt, code, fpc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic check_all(input int row, input vec_t v);
        check("imem_req", row, {31'b0, imem_bus.imem_req}, v.req);
        check("imem_addr", row, imem_bus.imem_addr, v.addr);
        check("instr", row, instr, v.instr);
        check("instr_valid", row, {31'b0, instr_valid}, v.iv);
        check("pc_stall", row, {31'b0, pc_stall}, v.stall);
        check("fault", row, {31'b0, fault}, v.flt);
        check("fault_code", row, {30'b0, fault_code}, v.code);
        check("fault_pc", row, fault_pc, v.fpc);
    endtask

    localparam logic [31:0] I1 = 32'h8C22_0004;
    localparam logic [31:0] IA = 32'hAAAA_0001;
    localparam logic [31:0] IB = 32'hBBBB_0002;
    localparam logic [31:0] IC = 32'hCCCC_0003;

    initial begin
        vec_t rv;
        // fe pc fl fc ack rdata | req addr instr iv stall flt code fpc
        vecs.push_back('{0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0});
        // aligned fetch, ack in first REQ cycle
        vecs.push_back('{1, 'h40, 0, 0, 0, 0,        0, 0, 0, 0, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, I1,          1, 'h40, 0, 0, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0,           0, 'h40, I1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 'h11111111,  0, 'h40, I1, 0, 0, 0, 0, 0});
        // misaligned -> fault, flush/ack ignored, clear
        vecs.push_back('{1, 'h42, 0, 0, 0, 0,        0, 'h40, I1, 0, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 0, 0,           0, 'h40, I1, 0, 1, 1, 1, 'h42});
        vecs.push_back('{0, 0, 0, 0, 1, 5,           0, 'h40, I1, 0, 1, 1, 1, 'h42});
        vecs.push_back('{0, 0, 0, 1, 0, 0,           0, 'h40, I1, 0, 1, 1, 1, 'h42});
        vecs.push_back('{0, 0, 0, 1, 0, 0,           0, 'h40, I1, 0, 0, 0, 0, 'h42});
        // timeout after 4 REQ cycles
        vecs.push_back('{1, 'h100, 0, 0, 0, 0,       0, 'h40, I1, 0, 1, 0, 0, 'h42});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{0, 0, 0, 0, 0, 0,       1, 'h100, I1, 0, 1, 0, 0, 'h42});
        vecs.push_back('{0, 0, 0, 0, 0, 0,           0, 'h100, I1, 0, 1, 1, 2, 'h100});
        vecs.push_back('{0, 0, 0, 1, 0, 0,           0, 'h100, I1, 0, 1, 1, 2, 'h100});
        // flush in second REQ cycle, ack in third -> discarded
        vecs.push_back('{1, 'h200, 0, 0, 0, 0,       0, 'h100, I1, 0, 1, 0, 0, 'h100});
        vecs.push_back('{0, 0, 0, 0, 0, 0,           1, 'h200, I1, 0, 1, 0, 0, 'h100});
        vecs.push_back('{0, 0, 1, 0, 0, 0,           1, 'h200, I1, 0, 1, 0, 0, 'h100});
        vecs.push_back('{0, 0, 0, 0, 1, 'hDEADBEEF,  1, 'h200, I1, 0, 1, 0, 0, 'h100});
        vecs.push_back('{0, 0, 0, 0, 0, 0,           0, 'h200, I1, 0, 0, 0, 0, 'h100});
        // back-to-back with fetch_en held
        vecs.push_back('{1, 0, 0, 0, 0, 0,           0, 'h200, I1, 0, 1, 0, 0, 'h100});
        vecs.push_back('{1, 0, 0, 0, 1, IA,          1, 0, I1, 0, 1, 0, 0, 'h100});
        vecs.push_back('{1, 4, 0, 0, 0, 0,           0, 0, IA, 1, 0, 0, 0, 'h100});
        vecs.push_back('{1, 4, 0, 0, 0, 0,           0, 0, IA, 0, 1, 0, 0, 'h100});
        vecs.push_back('{1, 4, 0, 0, 1, IB,          1, 4, IA, 0, 1, 0, 0, 'h100});
        vecs.push_back('{1, 8, 0, 0, 0, 0,           0, 4, IB, 1, 0, 0, 0, 'h100});
        vecs.push_back('{0, 0, 0, 0, 0, 0,           0, 4, IB, 0, 0, 0, 0, 'h100});
        // flush in DONE: no pulse, instr still updated
        vecs.push_back('{1, 'h10, 0, 0, 0, 0,        0, 4, IB, 0, 1, 0, 0, 'h100});
        vecs.push_back('{0, 0, 0, 0, 1, IC,          1, 'h10, IB, 0, 1, 0, 0, 'h100});
        vecs.push_back('{0, 0, 1, 0, 0, 0,           0, 'h10, IC, 0, 0, 0, 0, 'h100});
        vecs.push_back('{0, 0, 0, 0, 0, 0,           0, 'h10, IC, 0, 0, 0, 0, 'h100});

        reset_n             = 1'b0;
        pc                  = '0;
        fetch_en            = 1'b0;
        flush               = 1'b0;
        fault_clr           = 1'b0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_all(-1, rv);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            fetch_en            = vecs[i].fe[0];
            pc                  = vecs[i].pc;
            flush               = vecs[i].fl[0];
            fault_clr           = vecs[i].fc[0];
            imem_bus.imem_ack   = vecs[i].ack[0];
            imem_bus.imem_rdata = vecs[i].rdata;
            #1;
            check_all(i, vecs[i]);
        end

        // Reset asserted mid-REQ: request drops at once, later ack is ignored.
        @(negedge clk);
        fetch_en = 1'b1;
        pc = 32'h300;
        flush = 1'b0;
        fault_clr = 1'b0;
        imem_bus.imem_ack = 1'b0;
        @(negedge clk);
        #1;
        check("rst_req_before", 100, {31'b0, imem_bus.imem_req}, 32'd1);
        check("rst_addr_before", 100, imem_bus.imem_addr, 32'h300);
        #2;
        reset_n = 1'b0;
        #1;
        rv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_all(101, rv);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_instr_held", 102, instr, 32'h0);
        check("rst_req_held", 102, {31'b0, imem_bus.imem_req}, 32'd0);
        fetch_en = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ack_ignored", 103, instr, 32'h0);
        check("post_rst_req", 103, {31'b0, imem_bus.imem_req}, 32'd0);
        imem_bus.imem_ack = 1'b0;

        // First edge after reset release moves to REQ; then a normal completion.
        @(negedge clk);
        fetch_en = 1'b1;
        pc = 32'h20;
        @(posedge clk);
        #1;
        check("restart_req", 104, {31'b0, imem_bus.imem_req}, 32'd1);
        check("restart_addr", 104, imem_bus.imem_addr, 32'h20);
        fetch_en = 1'b0;
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'h0000_0077;
        @(posedge clk);
        #1;
        imem_bus.imem_ack = 1'b0;
        check("restart_valid", 105, {31'b0, instr_valid}, 32'd1);
        check("restart_instr", 105, instr, 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
